// File: rtl/state_dump_if.sv
// Word stream carrying dump frames from state_dump to its sink.
// The master drives word, valid and last; the slave answers with ready.
interface state_dump_if;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;

    modport master (output dout, dout_valid, dout_last, input dout_ready);
    modport slave  (input dout, dout_valid, dout_last, output dout_ready);
endinterface

// File: rtl/state_dump.sv
// CPU state dump engine: counts run/stall/flush cycles and, on request, freezes the
// CPU and streams a header, the register file and a data-memory window as one frame.
module state_dump #(
    parameter int NUM_MEM_WORDS = 8,
    parameter int CNT_W         = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         dump_req_i,
    input  logic [31:0]  pc_i,
    output logic [4:0]   reg_addr_o,
    input  logic [31:0]  reg_data_i,
    output logic [31:0]  dmem_addr_o,
    input  logic [31:0]  dmem_data_i,
    output logic         freeze_o,
    output logic         busy_o,
    state_dump_if.master dout_if
);

    typedef enum logic [1:0] {IDLE, HDR, REG, MEM} state_e;

    localparam logic [4:0]       MEM_LAST = 5'(NUM_MEM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             active;
    logic             xfer;
    logic             run;

    // Counters are reported as 32-bit words regardless of CNT_W.
    function automatic logic [31:0] to_word(input logic [CNT_W-1:0] v);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < CNT_W && b < 32; b++) begin
            w[b] = v[b];
        end
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    assign active             = (state_q != IDLE);
    assign xfer               = active && dout_if.dout_ready;
    assign run                = start_i && !active;
    assign freeze_o           = active;
    assign busy_o             = active;
    assign dout_if.dout_valid = active;

    always_comb begin
        cycle_cnt_d = sat_inc(cycle_cnt_q, run);
        stall_cnt_d = sat_inc(stall_cnt_q, run && stall_i);
        flush_cnt_d = sat_inc(flush_cnt_q, run && flush_i);
    end

    // Frame sequencer; idx walks the words of each section and only moves on a transfer.
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        reg_addr_o        = '0;
        dmem_addr_o       = '0;
        dout_if.dout      = '0;
        dout_if.dout_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_req_i) begin
                    state_d = HDR;
                    idx_d   = '0;
                end
            end
            HDR: begin
                case (idx_q[1:0])
                    2'd0:    dout_if.dout = to_word(cycle_cnt_q);
                    2'd1:    dout_if.dout = to_word(stall_cnt_q);
                    2'd2:    dout_if.dout = to_word(flush_cnt_q);
                    default: dout_if.dout = pc_i;
                endcase
                if (xfer) begin
                    if (idx_q == 5'd3) begin
                        state_d = REG;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            REG: begin
                reg_addr_o   = idx_q;
                dout_if.dout = reg_data_i;
                if (xfer) begin
                    if (idx_q == 5'd31) begin
                        state_d = MEM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            MEM: begin
                dmem_addr_o       = {25'd0, idx_q, 2'b00};
                dout_if.dout      = dmem_data_i;
                dout_if.dout_last = (idx_q == MEM_LAST);
                if (xfer) begin
                    if (idx_q == MEM_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_state_dump.sv
// Self-checking bench for state_dump: a frame-level reference model builds each expected
// frame as a queue of words at request time and consumes one entry per accepted word.
module tb_state_dump;

    localparam int     NW   = 8;
    localparam int     NW4  = 2;
    localparam longint CMAX = (64'd1 << 32) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, flush, dump_req;
    logic [31:0] pc;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data, dmem_addr, dmem_data;
    logic        freeze, busy;

    logic        start4, stall4, flush4, dump4;
    logic [31:0] pc4;
    logic [4:0]  reg_addr4;
    logic [31:0] reg_data4, dmem_addr4, dmem_data4;
    logic        freeze4, busy4;

    logic [31:0] regs [32];
    logic [31:0] mem  [32];

    longint      m_cycle, m_stall, m_flush;
    bit          m_frozen;
    logic [31:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    state_dump_if dbus ();
    state_dump_if dbus4 ();

    always #5 clk = ~clk;

    assign reg_data   = regs[reg_addr];
    assign dmem_data  = mem[dmem_addr[6:2]];
    assign reg_data4  = regs[reg_addr4];
    assign dmem_data4 = mem[dmem_addr4[6:2]];

    state_dump #(.NUM_MEM_WORDS(NW), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
        .dump_req_i(dump_req), .pc_i(pc), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
        .dmem_addr_o(dmem_addr), .dmem_data_i(dmem_data), .freeze_o(freeze), .busy_o(busy),
        .dout_if(dbus)
    );

    state_dump #(.NUM_MEM_WORDS(NW4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start4), .stall_i(stall4), .flush_i(flush4),
        .dump_req_i(dump4), .pc_i(pc4), .reg_addr_o(reg_addr4), .reg_data_i(reg_data4),
        .dmem_addr_o(dmem_addr4), .dmem_data_i(dmem_data4), .freeze_o(freeze4), .busy_o(busy4),
        .dout_if(dbus4)
    );

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_cycle  = 0;
        m_stall  = 0;
        m_flush  = 0;
        m_frozen = 0;
        exp_q.delete();
    endtask

    // One clock cycle, entered and left on a falling edge; advances the reference model.
    task automatic tick();
        bit xf, rq, adv;
        xf  = m_frozen && (dbus.dout_ready === 1'b1);
        rq  = !m_frozen && (dump_req === 1'b1);
        adv = !m_frozen && (start === 1'b1);
        @(posedge clk);
        if (rst_n === 1'b1) begin
            if (adv) begin
                m_cycle = sat(m_cycle + 1);
                if (stall === 1'b1) m_stall = sat(m_stall + 1);
                if (flush === 1'b1) m_flush = sat(m_flush + 1);
            end
            if (rq) begin
                exp_q.delete();
                exp_q.push_back(32'(m_cycle));
                exp_q.push_back(32'(m_stall));
                exp_q.push_back(32'(m_flush));
                exp_q.push_back(pc);
                for (int i = 0; i < 32; i++) exp_q.push_back(regs[i]);
                for (int i = 0; i < NW; i++) exp_q.push_back(mem[i]);
                m_frozen = 1;
            end else if (xf) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_frozen = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (freeze !== 1'b0) begin errors++; $display("[TB] FAIL reset_freeze: got %b expected 0", freeze); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dbus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", dbus.dout_valid); end
        checks++; if (dbus.dout_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", dbus.dout_last); end
        checks++; if (dbus.dout !== 32'd0) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 0", dbus.dout); end
        checks++; if (reg_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_reg_addr: got %h expected 0", reg_addr); end
        checks++; if (dmem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_dmem_addr: got %h expected 0", dmem_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Known counts and presets, ready tied high: 44 back-to-back words with fixed contents.
    task automatic test_basic();
        logic [31:0] gold [44];
        logic [31:0] mem_vals [8];
        mem_vals = '{32'd5, 32'd6, 32'd10, 32'd18, 32'd29, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < 8; i++) regs[24 + i] = (i < 4) ? 32'(-(24 + i)) : 32'(56 + 2 * (i - 4));
        for (int i = 0; i < 32; i++) mem[i] = (i < 8) ? mem_vals[i] : 32'd0;
        pc = 32'h0000_1000;
        gold[0] = 32'd10; gold[1] = 32'd2; gold[2] = 32'd1; gold[3] = pc;
        for (int i = 0; i < 32; i++) gold[4 + i] = regs[i];
        for (int i = 0; i < 8; i++) gold[36 + i] = mem_vals[i];
        dbus.dout_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stall = (i == 3 || i == 7);
            flush = (i == 5);
            tick();
        end
        start = 1'b0; stall = 1'b0; flush = 1'b0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int w = 1; w <= 44; w++) begin
            checks++; if (dbus.dout_valid !== 1'b1 || freeze !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("[TB] FAIL basic_valid w%0d: got v%b f%b b%b expected 111", w, dbus.dout_valid, freeze, busy);
            end
            checks++; if (dbus.dout !== gold[w-1]) begin
                errors++; $display("[TB] FAIL basic_word w%0d: got %h expected %h", w, dbus.dout, gold[w-1]);
            end
            checks++; if (dbus.dout_last !== (w == 44)) begin
                errors++; $display("[TB] FAIL basic_last w%0d: got %b expected %b", w, dbus.dout_last, (w == 44));
            end
            if (w >= 5 && w <= 36) begin
                checks++; if (reg_addr !== 5'(w - 5)) begin errors++; $display("[TB] FAIL basic_reg_addr w%0d: got %0d expected %0d", w, reg_addr, w - 5); end
            end
            if (w >= 37) begin
                checks++; if (dmem_addr !== 32'(4 * (w - 37))) begin errors++; $display("[TB] FAIL basic_dmem_addr w%0d: got %h expected %h", w, dmem_addr, 32'(4 * (w - 37))); end
            end
            tick();
        end
        checks++; if (dbus.dout_valid !== 1'b0 || freeze !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_end: got v%b f%b b%b expected 000", dbus.dout_valid, freeze, busy);
        end
    endtask

    // Random activity and random backpressure over two frames; counters must hold during a frame.
    task automatic test_random_ready();
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        for (int f = 0; f < 2; f++) begin
            int n = $urandom_range(5, 30);
            int cyc = 0;
            for (int i = 0; i < n; i++) begin
                start = ($urandom_range(0, 3) != 0);
                stall = $urandom_range(0, 1) == 1;
                flush = $urandom_range(0, 2) == 0;
                if (start) pc = pc + 32'd4;
                tick();
            end
            dump_req = 1'b1;
            tick();
            dump_req = 1'b0;
            while (m_frozen && cyc < 600) begin
                dbus.dout_ready = $urandom_range(0, 1) == 1;
                start = 1'b1;
                stall = $urandom_range(0, 1) == 1;
                flush = $urandom_range(0, 1) == 1;
                checks++; if (dbus.dout_valid !== 1'b1 || freeze !== 1'b1) begin
                    errors++; $display("[TB] FAIL rand_valid f%0d c%0d: got v%b f%b expected 11", f, cyc, dbus.dout_valid, freeze);
                end
                checks++; if (dbus.dout !== exp_q[0]) begin
                    errors++; $display("[TB] FAIL rand_word f%0d c%0d: got %h expected %h", f, cyc, dbus.dout, exp_q[0]);
                end
                checks++; if (dbus.dout_last !== (exp_q.size() == 1)) begin
                    errors++; $display("[TB] FAIL rand_last f%0d c%0d: got %b expected %b", f, cyc, dbus.dout_last, (exp_q.size() == 1));
                end
                tick();
                cyc++;
            end
            checks++; if (m_frozen) begin errors++; $display("[TB] FAIL rand_timeout f%0d: got %0d words left expected 0", f, exp_q.size()); end
            start = 1'b0; stall = 1'b0; flush = 1'b0;
            dbus.dout_ready = 1'b1;
        end
    endtask

    // Requests at word 20 and on the last-word edge must neither restart nor queue a frame.
    task automatic test_ignore_requests();
        int words = 0;
        dbus.dout_ready = 1'b1;
        dump_req = 1'b1;
        tick();
        for (int w = 1; w <= 44 && m_frozen; w++) begin
            dump_req = (w == 20 || w == 44);
            checks++; if (dbus.dout !== exp_q[0] || dbus.dout_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL ign_word w%0d: got %h/%b expected %h/1", w, dbus.dout, dbus.dout_valid, exp_q[0]);
            end
            words++;
            tick();
        end
        dump_req = 1'b0;
        checks++; if (words != 44 || m_frozen) begin errors++; $display("[TB] FAIL ign_count: got %0d expected 44", words); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (dbus.dout_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("[TB] FAIL ign_idle c%0d: got v%b b%b expected 00", i, dbus.dout_valid, busy);
            end
            tick();
        end
    endtask

    // Asynchronous reset in the middle of a frame, then a complete fresh frame.
    task automatic test_reset_midframe();
        int words = 0;
        int cyc = 0;
        dbus.dout_ready = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if ({dbus.dout_valid, dbus.dout_last, freeze, busy} !== 4'b0000) begin
            errors++; $display("[TB] FAIL mid_rst_ctrl: got %b expected 0000", {dbus.dout_valid, dbus.dout_last, freeze, busy});
        end
        checks++; if (dbus.dout !== 32'd0 || reg_addr !== 5'd0 || dmem_addr !== 32'd0) begin
            errors++; $display("[TB] FAIL mid_rst_data: got %h/%h/%h expected 0/0/0", dbus.dout, reg_addr, dmem_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (dbus.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle c%0d: got %b expected 0", i, dbus.dout_valid); end
            tick();
        end
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        while (m_frozen && cyc < 100) begin
            checks++; if (dbus.dout !== exp_q[0] || dbus.dout_last !== (exp_q.size() == 1)) begin
                errors++; $display("[TB] FAIL mid_word w%0d: got %h/%b expected %h/%b", words + 1, dbus.dout, dbus.dout_last, exp_q[0], (exp_q.size() == 1));
            end
            words++;
            cyc++;
            tick();
        end
        checks++; if (words != 44) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 44", words); end
    endtask

    // 4-bit counters: 20 run cycles, 17 stalls, 3 flushes -> 15, 15, 3.
    task automatic test_saturation();
        logic [31:0] hdr [3];
        hdr = '{32'd15, 32'd15, 32'd3};
        dbus4.dout_ready = 1'b1;
        start4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stall4 = (i < 17);
            flush4 = (i < 3);
            tick();
        end
        start4 = 1'b0; stall4 = 1'b0; flush4 = 1'b0;
        dump4 = 1'b1;
        tick();
        dump4 = 1'b0;
        for (int w = 1; w <= 36 + NW4; w++) begin
            checks++; if (dbus4.dout_valid !== 1'b1 || freeze4 !== 1'b1 || busy4 !== 1'b1) begin
                errors++; $display("[TB] FAIL sat_valid w%0d: got v%b f%b b%b expected 111", w, dbus4.dout_valid, freeze4, busy4);
            end
            if (w <= 3) begin
                checks++; if (dbus4.dout !== hdr[w-1]) begin errors++; $display("[TB] FAIL sat_hdr w%0d: got %0d expected %0d", w, dbus4.dout, hdr[w-1]); end
            end
            checks++; if (dbus4.dout_last !== (w == 36 + NW4)) begin
                errors++; $display("[TB] FAIL sat_last w%0d: got %b expected %b", w, dbus4.dout_last, (w == 36 + NW4));
            end
            if (w == 36 + NW4) begin
                checks++; if (dmem_addr4 !== 32'd4) begin errors++; $display("[TB] FAIL sat_dmem_addr: got %h expected 4", dmem_addr4); end
            end
            tick();
        end
        checks++; if (dbus4.dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_end: got %b expected 0", dbus4.dout_valid); end
    endtask

    initial begin
        start = 1'b0; stall = 1'b0; flush = 1'b0; dump_req = 1'b0; pc = 32'd0;
        start4 = 1'b0; stall4 = 1'b0; flush4 = 1'b0; dump4 = 1'b0; pc4 = 32'h0000_2000;
        dbus.dout_ready = 1'b1;
        dbus4.dout_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'd0;
            mem[i]  = 32'd0;
        end
        test_reset();
        test_basic();
        test_random_ready();
        test_ignore_requests();
        test_reset_midframe();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
